// File: rtl/alu_uart_ctrl_pkg.sv
// Shared ALU opcode encodings used by the ALU and by its UART sequencer.
package alu_uart_ctrl_pkg;

    localparam int unsigned NB_ALU_OP = 6;

    localparam logic [NB_ALU_OP-1:0] IDLE_OP = 6'h3F;
    localparam logic [NB_ALU_OP-1:0] ADD_OP  = 6'h20;
    localparam logic [NB_ALU_OP-1:0] SUB_OP  = 6'h22;
    localparam logic [NB_ALU_OP-1:0] AND_OP  = 6'h24;
    localparam logic [NB_ALU_OP-1:0] OR_OP   = 6'h25;
    localparam logic [NB_ALU_OP-1:0] XOR_OP  = 6'h26;
    localparam logic [NB_ALU_OP-1:0] NOR_OP  = 6'h27;
    localparam logic [NB_ALU_OP-1:0] SRL_OP  = 6'h02;
    localparam logic [NB_ALU_OP-1:0] SRA_OP  = 6'h03;

endpackage

// File: rtl/alu_uart_ctrl.sv
// Sequencer between the UART byte link and the combinational ALU: gathers
// opcode/A/B bytes, holds them stable on the ALU inputs, latches the result
// and returns it byte-serially (little-endian) over the UART TX.
module alu_uart_ctrl
    import alu_uart_ctrl_pkg::*;
#(
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned NB_DATA = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_alu_data_a,
    output logic [NB_DATA-1:0] o_alu_data_b,
    output logic [4:0]         o_alu_shamt,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_error
);

    localparam int unsigned NB_BYTES = NB_DATA / 8;
    localparam int unsigned NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_A,
        ST_RX_B,
        ST_EXEC,
        ST_TX_LOAD,
        ST_TX_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [NB_OP-1:0]    op_q, op_d;
    logic [NB_DATA-1:0]  a_q, a_d;
    logic [NB_DATA-1:0]  b_q, b_d;
    logic [NB_DATA-1:0]  res_q, res_d;
    logic [NB_CNT-1:0]   cnt_q, cnt_d;
    logic [NB_CNT-1:0]   cnt_inc;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;

    // Next-state and next-register values for the whole sequencer.
    // The TX byte and start pulse are registered on entry to TX_LOAD so that
    // o_tx_data is already valid in the cycle o_tx_start is high.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        error_d    = 1'b0;
        cnt_inc    = cnt_q + NB_CNT'(1);

        case (state_q)
            ST_IDLE: begin
                if (i_rx_done) begin
                    if ((i_rx_data >> NB_OP) == 8'd0) begin
                        op_d    = i_rx_data[NB_OP-1:0];
                        cnt_d   = '0;
                        state_d = ST_RX_A;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_RX_A: begin
                if (i_rx_done) begin
                    for (int unsigned i = 0; i < NB_BYTES; i++) begin
                        if (cnt_q == NB_CNT'(i)) a_d[8*i +: 8] = i_rx_data;
                    end
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = ST_RX_B;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_RX_B: begin
                if (i_rx_done) begin
                    for (int unsigned i = 0; i < NB_BYTES; i++) begin
                        if (cnt_q == NB_CNT'(i)) b_d[8*i +: 8] = i_rx_data;
                    end
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = ST_EXEC;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_EXEC: begin
                res_d      = i_alu_result;
                cnt_d      = '0;
                tx_data_d  = i_alu_result[7:0];
                tx_start_d = 1'b1;
                state_d    = ST_TX_LOAD;
            end
            ST_TX_LOAD: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (i_tx_done) begin
                    if (cnt_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                        for (int unsigned i = 0; i < NB_BYTES; i++) begin
                            if (cnt_inc == NB_CNT'(i)) tx_data_d = res_q[8*i +: 8];
                        end
                        tx_start_d = 1'b1;
                        state_d    = ST_TX_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            op_q       <= NB_OP'(IDLE_OP);
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    assign o_alu_op     = op_q;
    assign o_alu_data_a = a_q;
    assign o_alu_data_b = b_q;
    assign o_alu_shamt  = a_q[4:0];
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_busy       = busy_q;
    assign o_error      = error_q;

endmodule
